counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, width of counter value and limit.
REQ-002 clk  input  1  rising-edge clock; the block has one clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  block can accept a command; a command is accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 cmd_op  input  2  opcode: 00 START, 01 STOP, 10 RESUME, 11 CLEAR.
REQ-007 cmd_limit  input  WIDTH  terminal value, latched only on an accepted START.
REQ-008 cmd_reload  input  1  1 = auto-reload (periodic), 0 = one-shot; latched only on an accepted START.
REQ-009 value  output  WIDTH  current count.
REQ-010 busy  output  1  high only in state RUN.
REQ-011 done  output  1  high only in state DONE.
REQ-012 tc  output  1  one-cycle terminal-count pulse.
REQ-013 err  output  1  one-cycle pulse for an accepted illegal command.

Function
REQ-014 FSM states: IDLE, RUN, PAUSE, DONE; all outputs are registered.
REQ-015 cmd_ready is 0 while reset is asserted and is 1 from the first rising edge after reset deassertion onward.
REQ-016 Accepted START in any state: value<=0; latch limit and reload; next state RUN.
REQ-017 Accepted STOP in RUN: next state PAUSE; value holds.
REQ-018 Accepted RESUME in PAUSE: next state RUN; value holds on that edge.
REQ-019 Accepted CLEAR in any state: next state IDLE; value<=0.
REQ-020 STOP outside RUN, or RESUME outside PAUSE: state and value unchanged; err=1 for one cycle.
REQ-021 RUN with no accepted command and value != limit: value<=value+1 each edge.
REQ-022 RUN with no accepted command and value == limit: tc=1 on the next cycle; with reload=1, value<=0 and state stays RUN; with reload=0, value holds limit and next state DONE.
REQ-023 Period in reload mode is limit+1 cycles; limit=0 with reload=1 produces tc every RUN cycle.
REQ-024 Simultaneous accepted command and terminal condition: the command wins, and tc is not asserted on that edge.
REQ-025 No arithmetic wrap occurs: value never exceeds the latched limit, and value+1 is computed at WIDTH bits.
REQ-026 IDLE, PAUSE and DONE hold value; tc=0 in those states unless REQ-022 produced the pulse on entry to DONE.
REQ-027 err and tc are each 1 for exactly one cycle per event and 0 otherwise.

Reset
REQ-028 Reset assertion forces the following immediately, independent of clk: state IDLE, value=0, busy=0, done=0, tc=0, err=0, cmd_ready=0, latched limit=0, reload=0.
REQ-029 Reset asserted mid-RUN or mid-PAUSE aborts the operation; no tc and no err are generated.
REQ-030 Commands offered while reset is asserted are ignored.

Verification
REQ-031 One-shot: START with limit=5, reload=0 -> value 0,1,2,3,4,5 on consecutive cycles; tc=1 for one cycle; done=1 and value holds 5; busy=0.
REQ-032 Periodic: START with limit=3, reload=1, run 12 cycles -> value follows 0,1,2,3,0,..., and tc pulses every 4 cycles (3 pulses); done stays 0.
REQ-033 Pause/resume: START limit=10, STOP when value=4, wait 5 cycles, RESUME -> value holds 4 while paused, then continues 5..10; tc fires once.
REQ-034 Collision: CLEAR accepted on the edge where value==limit (limit=7) -> state IDLE, value=0, tc stays 0.
REQ-035 Illegal commands: RESUME in IDLE -> err pulse, state IDLE; STOP in DONE -> err pulse, done stays 1.
REQ-036 Async reset: assert reset mid-RUN at value=6 between clock edges -> all outputs 0 immediately; after release, cmd_ready=1 at the first edge.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven up-counter with one-shot and periodic modes.
// Start/stop/resume/clear control, terminal-count and illegal-command pulses.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_reload,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             ready_q;
    logic             accept;

    assign accept = cmd_valid & ready_q;

    // Next state: an accepted command always beats the terminal condition.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        err_d    = 1'b0;
        if (accept) begin
            unique case (cmd_op)
                OP_START: begin
                    value_d  = '0;
                    limit_d  = cmd_limit;
                    reload_d = cmd_reload;
                    state_d  = RUN;
                end
                OP_STOP: begin
                    if (state_q == RUN) state_d = PAUSE;
                    else                err_d   = 1'b1;
                end
                OP_RESUME: begin
                    if (state_q == PAUSE) state_d = RUN;
                    else                  err_d   = 1'b1;
                end
                OP_CLEAR: begin
                    value_d = '0;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end else if (state_q == RUN) begin
            if (value_q != limit_q) begin
                value_d = value_q + WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (reload_q) value_d = '0;
                else          state_d = DONE;
            end
        end
    end

    // State and datapath registers; reset aborts everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            value_q  <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
            ready_q  <= 1'b1;
        end
    end

    assign cmd_ready = ready_q;
    assign value     = value_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign tc        = tc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed vectors for counter_ctrl.
// Expected values are hand-derived from the command sequence.
module tb_counter_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_limit;
    logic         cmd_reload;
    logic [W-1:0] value;
    logic         busy;
    logic         done;
    logic         tc;
    logic         err;

    int n_vec;
    int n_bad;
    int tc_cnt;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_limit  (cmd_limit),
        .cmd_reload (cmd_reload),
        .value      (value),
        .busy       (busy),
        .done       (done),
        .tc         (tc),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] lim,
                       input logic rl);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_limit  = lim;
        cmd_reload = rl;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] v,
                           input logic b, input logic d,
                           input logic t, input logic e);
        chk({tag, ".value"}, 32'(value), 32'(v));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".err"},   32'(err),   32'(e));
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_op     = 2'b00;
        cmd_limit  = 8'd3;
        cmd_reload = 1'b0;

        // Reset asserted with a START offered: must be ignored.
        #2;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk_all("rst0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_ready2", 32'(cmd_ready), 32'd0);
        chk_all("rst1", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();
        chk("ready_up", 32'(cmd_ready), 32'd1);
        chk_all("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-shot, limit 5.
        cmd(2'b00, 8'd5, 1'b0);
        chk_all("os0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all($sformatf("os%0d", i), W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("os_tc", 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("os_hold", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);

        // STOP in DONE is illegal.
        cmd(2'b01, 8'd0, 1'b0);
        chk_all("stop_done", 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("stop_done2", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);

        // CLEAR, then RESUME in IDLE is illegal.
        cmd(2'b11, 8'd0, 1'b0);
        chk_all("clr", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd(2'b10, 8'd0, 1'b0);
        chk_all("res_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("res_idle2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Periodic, limit 3, 12 cycles.
        cmd(2'b00, 8'd3, 1'b1);
        chk_all("per0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tc_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (tc) tc_cnt++;
            chk_all($sformatf("per%0d", i), W'(i % 4), 1'b1, 1'b0,
                    (i % 4) == 0, 1'b0);
        end
        chk("per_tc_cnt", 32'(tc_cnt), 32'd3);

        // Limit 0 periodic: tc every RUN cycle.
        cmd(2'b00, 8'd0, 1'b1);
        chk_all("z0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("z1", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("z2", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Pause / resume, limit 10.
        cmd(2'b00, 8'd10, 1'b0);
        chk_all("pr0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tc_cnt = 0;
        for (int i = 1; i <= 4; i++) tick();
        chk_all("pr4", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(2'b01, 8'd0, 1'b0);
        chk_all("pr_stop", 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("pr_p%0d", i), 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cmd(2'b10, 8'd0, 1'b0);
        chk_all("pr_res", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i <= 10; i++) begin
            tick();
            if (tc) tc_cnt++;
            chk_all($sformatf("pr%0d", i), W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        if (tc) tc_cnt++;
        chk_all("pr_end", 8'd10, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        if (tc) tc_cnt++;
        chk("pr_tc_cnt", 32'(tc_cnt), 32'd1);

        // Collision: CLEAR on the terminal edge, limit 7.
        cmd(2'b00, 8'd7, 1'b0);
        for (int i = 1; i <= 7; i++) tick();
        chk_all("col7", 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(2'b11, 8'd0, 1'b0);
        chk_all("col_clr", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("col_clr2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-RUN at value 6.
        cmd(2'b00, 8'd9, 1'b0);
        for (int i = 1; i <= 6; i++) tick();
        chk_all("ar6", 8'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ready", 32'(cmd_ready), 32'd0);
        chk_all("ar", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("ar_hold", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("ar_ready2", 32'(cmd_ready), 32'd1);
        chk_all("ar_rel", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
